// File: rtl/receptor_uart.sv
// receptor_uart: 16x-oversampled UART receiver, mid-bit sampling, LSB first.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module receptor_uart #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICKS  = 16
) (
    input  logic                 clock50M,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 rx_done,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 busy
);

    localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [3:0]    SB_LAST = 4'(SB_TICKS - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(DATA_BITS - 1);
    localparam logic [NW-1:0] N_ONE   = NW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // synchronizer and edge-detect history
    logic                 r_sync1;
    logic                 r_rx_s;
    logic                 r_rx_p;

    // frame state
    state_t               r_state;
    logic [3:0]           r_s;
    logic [NW-1:0]        r_n;
    logic [DATA_BITS-1:0] r_b;

    // delivered results
    logic [DATA_BITS-1:0] r_data;
    logic                 r_done;
    logic                 r_fe;

    // next-state values
    state_t               w_state_nx;
    logic [3:0]           w_s_nx;
    logic [NW-1:0]        w_n_nx;
    logic [DATA_BITS-1:0] w_b_nx;
    logic [DATA_BITS-1:0] w_data_nx;
    logic                 w_done_nx;
    logic                 w_fe_nx;
    logic                 w_fall;
    logic [DATA_BITS-1:0] w_shifted;

`ifdef UART_RX_PARITY_EN
    logic                 r_par;
    logic                 r_pe;
    logic                 w_par_nx;
    logic                 w_pe_nx;
`endif

    assign w_fall    = ~r_rx_s & r_rx_p;
    assign w_shifted = (r_b >> 1)
                     | (DATA_BITS'(r_rx_s) << (DATA_BITS - 1));

    // bring rx into the clock domain; idle level is 1
    always_ff @(posedge clock50M or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_p  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
            r_rx_p  <= r_rx_s;
        end
    end

    // FSM and datapath registers
    always_ff @(posedge clock50M or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_fe    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_s     <= w_s_nx;
            r_n     <= w_n_nx;
            r_b     <= w_b_nx;
            r_data  <= w_data_nx;
            r_done  <= w_done_nx;
            r_fe    <= w_fe_nx;
        end
    end

`ifdef UART_RX_PARITY_EN
    // received parity bit and its check result
    always_ff @(posedge clock50M or negedge reset) begin
        if (!reset) begin
            r_par <= 1'b0;
            r_pe  <= 1'b0;
        end else begin
            r_par <= w_par_nx;
            r_pe  <= w_pe_nx;
        end
    end
`endif

    // next-state logic: every counter only moves on a tick
    always_comb begin
        w_state_nx = r_state;
        w_s_nx     = r_s;
        w_n_nx     = r_n;
        w_b_nx     = r_b;
        w_data_nx  = r_data;
        w_done_nx  = 1'b0;
        w_fe_nx    = r_fe;
`ifdef UART_RX_PARITY_EN
        w_par_nx   = r_par;
        w_pe_nx    = r_pe;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nx = S_START;
                    w_s_nx     = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (r_s == 4'd7) begin
                        w_s_nx = '0;
                        if (!r_rx_s) begin
                            w_state_nx = S_DATA;
                            w_n_nx     = '0;
                        end else begin
                            w_state_nx = S_IDLE;
                        end
                    end else begin
                        w_s_nx = r_s + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (r_s == 4'd15) begin
                        w_s_nx = '0;
                        w_b_nx = w_shifted;
                        if (r_n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nx = S_PARITY;
`else
                            w_state_nx = S_STOP;
`endif
                        end else begin
                            w_n_nx = r_n + N_ONE;
                        end
                    end else begin
                        w_s_nx = r_s + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    if (r_s == 4'd15) begin
                        w_s_nx     = '0;
                        w_par_nx   = r_rx_s;
                        w_state_nx = S_STOP;
                    end else begin
                        w_s_nx = r_s + 4'd1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (r_s == SB_LAST) begin
                        w_s_nx     = '0;
                        w_data_nx  = r_b;
                        w_fe_nx    = ~r_rx_s;
                        w_done_nx  = 1'b1;
                        w_state_nx = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        w_pe_nx    = ^{r_b, r_par};
`endif
                    end else begin
                        w_s_nx = r_s + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign data        = r_data;
    assign rx_done     = r_done;
    assign frame_error = r_fe;
    assign busy        = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_error = r_pe;
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_receptor_uart.sv
// tb_receptor_uart: random + directed frames, queue scoreboard,
// expectations derived from the line-level frame contents.
module tb_receptor_uart;

    localparam int DB  = 8;
    localparam int TPB = 27;
    localparam int BIT = 16 * TPB;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NT     = 8 + 16 * DB + 16 + (PAR ? 16 : 0);
    localparam int LAT_LO = NT * TPB - 40;
    localparam int LAT_HI = NT * TPB + 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick = 1'b0;
    logic          rx = 1'b1;
    logic [DB-1:0] data;
    logic          rx_done;
    logic          frame_error;
    logic          parity_error;
    logic          busy;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        longint     t;
    } exp_t;

    exp_t   q[$];
    int     tests = 0;
    int     fails = 0;
    longint cyc = 0;
    logic   busy_prev = 1'b0;

    receptor_uart #(.DATA_BITS(DB), .SB_TICKS(16)) dut (
        .clock50M    (clk),
        .reset       (rst_n),
        .tick        (tick),
        .rx          (rx),
        .data        (data),
        .rx_done     (rx_done),
        .frame_error (frame_error),
        .parity_error(parity_error),
        .busy        (busy)
    );

    always #10 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // one-clock tick every 27 clocks
    initial forever begin
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (TPB - 2) @(negedge clk);
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (BIT) @(negedge clk);
    endtask

    // drive one frame; abort_at >= 0 stops before that data bit
    task automatic send(input logic [7:0] d, input logic pb,
                        input logic sb, input int abort_at);
        exp_t e;
        @(negedge clk);
        e.d  = d;
        e.fe = ~sb;
        e.pe = PAR ? ^{d, pb} : 1'b0;
        e.t  = cyc;
        if (abort_at < 0) q.push_back(e);
        bit_time(1'b0);
        for (int i = 0; i < DB; i++) begin
            if (abort_at == i) return;
            bit_time(d[i]);
        end
        if (PAR) bit_time(pb);
        bit_time(sb);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin : mon
        exp_t   e;
        longint lat;
        if (rst_n && rx_done) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rx_done: got data %0h want none",
                         data);
            end else begin
                e = q.pop_front();
                lat = cyc - e.t;
                check("data", 32'(data), 32'(e.d));
                check("frame_error", 32'(frame_error), 32'(e.fe));
                check("parity_error", 32'(parity_error), 32'(e.pe));
                check("busy_at_done", 32'(busy), 32'd0);
                check("busy_before_done", 32'(busy_prev), 32'd1);
                tests++;
                if (lat < LAT_LO || lat > LAT_HI) begin
                    fails++;
                    $display("FAIL latency: got %0d want %0d..%0d",
                             lat, LAT_LO, LAT_HI);
                end
            end
        end
        busy_prev = busy;
    end

    initial begin
        logic [7:0] d;
        logic       sb;
        logic       pb;
        int         gap;

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data", 32'(data), 32'd0);
        check("rst_done", 32'(rx_done), 32'd0);
        check("rst_fe", 32'(frame_error), 32'd0);
        check("rst_pe", 32'(parity_error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (2000) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_data", 32'(data), 32'd0);

        send(8'h55, 1'b0, 1'b1, -1);
        bit_time(1'b1);

        // glitch: 108 clocks low must not start a frame
        @(negedge clk);
        rx = 1'b0;
        repeat (50) @(negedge clk);
        check("glitch_busy_hi", 32'(busy), 32'd1);
        repeat (58) @(negedge clk);
        rx = 1'b1;
        repeat (142) @(negedge clk);
        check("glitch_busy_lo", 32'(busy), 32'd0);
        repeat (500) @(negedge clk);

        // reset in the middle of bit 3 of 0x3C
        send(8'h3C, 1'b0, 1'b1, 3);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_data", 32'(data), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (2000) @(negedge clk);
        check("abort_data_after", 32'(data), 32'd0);
        check("abort_busy_after", 32'(busy), 32'd0);

        // framing error followed by a held-low break
        send(8'hA3, ^8'hA3, 1'b0, -1);
        rx = 1'b0;
        repeat (5000) @(negedge clk);
        check("break_busy", 32'(busy), 32'd0);
        rx = 1'b1;
        repeat (1000) @(negedge clk);

        // back-to-back frames
        send(8'h00, 1'b0, 1'b1, -1);
        send(8'hFF, 1'b0, 1'b1, -1);
        bit_time(1'b1);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1, -1);
        bit_time(1'b1);
        send(8'h07, 1'b0, 1'b1, -1);
        bit_time(1'b1);
`endif

        for (int k = 0; k < 20; k++) begin
            d   = 8'($urandom);
            sb  = ($urandom_range(0, 3) != 0);
            pb  = 1'($urandom_range(0, 1));
            send(d, pb, sb, -1);
            gap = sb ? int'($urandom_range(0, 300))
                     : int'($urandom_range(20, 300));
            rx  = 1'b1;
            repeat (gap) @(negedge clk);
        end

        rx = 1'b1;
        repeat (3000) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
